// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU codes,
// FSM states, instruction classes and per-class datapath controls.
package mc_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_HALT = 7'b1111111;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_MUL = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CL_NONE = 4'd0,
        CL_R    = 4'd1,
        CL_I    = 4'd2,
        CL_LW   = 4'd3,
        CL_SW   = 4'd4,
        CL_B    = 4'd5,
        CL_JAL  = 4'd6,
        CL_JALR = 4'd7,
        CL_HALT = 4'd8,
        CL_MUL  = 4'd9
    } iclass_t;

    typedef struct packed {
        logic mem_to_reg;
        logic alu_src;
        logic pc_to_reg;
        logic alu_to_pc;
    } dp_ctrl_t;

    // Datapath steering that depends only on the instruction class
    function automatic dp_ctrl_t class_ctrl(input iclass_t c);
        dp_ctrl_t d;
        d = '0;
        case (c)
            CL_I:    d.alu_src = 1'b1;
            CL_LW:   begin d.mem_to_reg = 1'b1; d.alu_src = 1'b1; end
            CL_SW:   d.alu_src = 1'b1;
            CL_JAL:  begin d.alu_src = 1'b1; d.pc_to_reg = 1'b1; end
            CL_JALR: begin d.alu_src = 1'b1; d.pc_to_reg = 1'b1; d.alu_to_pc = 1'b1; end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Request/ready handshake bundle between the control unit (master) and the
// instruction and data memories (slave).
interface mc_control_unit_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;

    modport master (output imem_req, dmem_req, input imem_ready, dmem_ready);
    modport slave  (input imem_req, dmem_req, output imem_ready, dmem_ready);
endinterface

// File: rtl/mc_control_unit_decoder.sv
// Combinational instruction classifier. Optional MUL_EN macro adds the
// R-type multiply encoding (func7=0000001, func3=000).
module mc_decoder
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output iclass_t    iclass,
    output logic [2:0] alu_op,
    output logic       valid
);

    always_comb begin
        iclass = CL_NONE;
        alu_op = ALU_ADD;
        valid  = 1'b0;
        case (opcode)
            OP_R: begin
                iclass = CL_R;
                valid  = 1'b1;
                case ({func7, func3})
                    {7'b0000000, 3'b000}: alu_op = ALU_ADD;
                    {7'b0100000, 3'b000}: alu_op = ALU_SUB;
                    {7'b0000000, 3'b111}: alu_op = ALU_AND;
                    {7'b0000000, 3'b110}: alu_op = ALU_OR;
                    {7'b0000000, 3'b001}: alu_op = ALU_SLL;
`ifdef MUL_EN
                    {7'b0000001, 3'b000}: begin
                        iclass = CL_MUL;
                        alu_op = ALU_MUL;
                    end
`endif
                    default: begin
                        iclass = CL_NONE;
                        valid  = 1'b0;
                    end
                endcase
            end
            OP_I: begin
                iclass = CL_I;
                valid  = 1'b1;
                case (func3)
                    3'b000: alu_op = ALU_ADD;
                    3'b111: alu_op = ALU_AND;
                    3'b110: alu_op = ALU_OR;
                    // shift-immediate keeps func7 as a real opcode extension
                    3'b001: begin
                        alu_op = ALU_SLL;
                        valid  = (func7 == 7'b0000000);
                    end
                    default: valid = 1'b0;
                endcase
                if (!valid) iclass = CL_NONE;
            end
            OP_LW: begin
                valid  = (func3 == 3'b010);
                iclass = valid ? CL_LW : CL_NONE;
            end
            OP_SW: begin
                valid  = (func3 == 3'b010);
                iclass = valid ? CL_SW : CL_NONE;
            end
            OP_B: begin
                valid  = (func3 == 3'b000);
                iclass = valid ? CL_B : CL_NONE;
                alu_op = ALU_SUB;
            end
            OP_JAL: begin
                valid  = 1'b1;
                iclass = CL_JAL;
            end
            OP_JALR: begin
                valid  = (func3 == 3'b000);
                iclass = valid ? CL_JALR : CL_NONE;
            end
            OP_HALT: begin
                valid  = 1'b1;
                iclass = CL_HALT;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with bounded memory waits
// and absorbing HALT/TRAP states. Optional MUL_EN macro enables multiply.
module mc_control_unit
    import mc_pkg::*;
#(
    parameter int ALUOP_W      = 3,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                mul_done,
    mc_control_unit_if.master   bus,
    output logic                ir_we,
    output logic                pc_we,
    output logic                BR,
    output logic                memToReg,
    output logic                memWrite,
    output logic                ALUSrc,
    output logic                regWrite,
    output logic                PCToReg,
    output logic                aluToPC,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                mul_start,
    output logic                halt,
    output logic                illegal,
    output logic                bus_err,
    output logic [2:0]          state
);

    state_t     state_q, state_d;
    logic       run_q;
    logic [7:0] wait_q;
    iclass_t    cls_q;
    logic [2:0] alu_q;
    dp_ctrl_t   ctrl_q;
    logic       halt_q, illegal_q, bus_err_q;

    iclass_t    dec_cls;
    logic [2:0] dec_alu;
    logic       dec_valid;
    logic       imem_req, dmem_req;
    logic       timeout, dec_fail, wait_last;

    mc_decoder u_dec (
        .opcode (instr[6:0]),
        .func3  (instr[14:12]),
        .func7  (instr[31:25]),
        .iclass (dec_cls),
        .alu_op (dec_alu),
        .valid  (dec_valid)
    );

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};
`ifndef MUL_EN
    logic unused_mul_done;
    assign unused_mul_done = mul_done;
`endif

    assign wait_last = (wait_q == 8'(MEM_WAIT_MAX - 1));

    // run_q keeps FETCH quiet until the first edge after reset release
    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        memWrite  = 1'b0;
        pc_we     = 1'b0;
        regWrite  = 1'b0;
        BR        = 1'b0;
        mul_start = 1'b0;
        timeout   = 1'b0;
        dec_fail  = 1'b0;
        case (state_q)
            ST_FETCH: if (run_q) begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_last) begin
                    timeout = 1'b1;
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (!dec_valid) begin
                    dec_fail = 1'b1;
                    state_d  = ST_TRAP;
                end else if (dec_cls == CL_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls_q)
                    CL_LW, CL_SW: state_d = ST_MEM;
                    CL_B: begin
                        BR      = 1'b1;
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end
`ifdef MUL_EN
                    CL_MUL: begin
                        mul_start = (wait_q == 8'd0);
                        if (mul_done) begin
                            state_d = ST_WB;
                        end else if (wait_last) begin
                            timeout = 1'b1;
                            state_d = ST_TRAP;
                        end
                    end
`endif
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                memWrite = (cls_q == CL_SW);
                if (bus.dmem_ready) begin
                    if (cls_q == CL_SW) begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_last) begin
                    timeout = 1'b1;
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                regWrite = 1'b1;
                pc_we    = 1'b1;
                state_d  = ST_FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            run_q     <= 1'b0;
            wait_q    <= 8'd0;
            cls_q     <= CL_NONE;
            alu_q     <= ALU_ADD;
            ctrl_q    <= '0;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            if (state_d != state_q)
                wait_q <= 8'd0;
            else if (run_q && (state_q inside {ST_FETCH, ST_EXEC, ST_MEM}))
                wait_q <= wait_q + 8'd1;
            // controls latched once per instruction and held until the next decode
            if (state_q == ST_DECODE) begin
                if (dec_valid && dec_cls != CL_HALT) begin
                    cls_q  <= dec_cls;
                    alu_q  <= dec_alu;
                    ctrl_q <= class_ctrl(dec_cls);
                end else begin
                    cls_q  <= CL_NONE;
                    alu_q  <= ALU_ADD;
                    ctrl_q <= '0;
                end
            end
            halt_q    <= halt_q | (state_d == ST_HALT);
            illegal_q <= illegal_q | dec_fail;
            bus_err_q <= bus_err_q | timeout;
        end
    end

    assign bus.imem_req = imem_req;
    assign bus.dmem_req = dmem_req;
    assign memToReg     = ctrl_q.mem_to_reg;
    assign ALUSrc       = ctrl_q.alu_src;
    assign PCToReg      = ctrl_q.pc_to_reg;
    assign aluToPC      = ctrl_q.alu_to_pc;
    assign ALUOp        = ALUOP_W'(alu_q);
    assign halt         = halt_q;
    assign illegal      = illegal_q;
    assign bus_err      = bus_err_q;
    assign state        = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: directed scenarios plus random
// instructions checked against an instruction-level timing/behaviour model.
module tb_mc_control_unit;

    localparam int MEM_WAIT_MAX = 15;
    localparam int K_ILL = 0, K_HALT = 1, K_ALU = 2, K_B = 3, K_LW = 4, K_SW = 5, K_MUL = 6;

    logic        clk, rst;
    logic [31:0] instr;
    logic        mul_done;
    logic        ir_we, pc_we, BR, memToReg, memWrite, ALUSrc, regWrite, PCToReg, aluToPC;
    logic [2:0]  ALUOp;
    logic        mul_start, halt, illegal, bus_err;
    logic [2:0]  state;
    int          checks = 0;
    int          failures = 0;

    mc_control_unit_if bus ();

    mc_control_unit #(.ALUOP_W(3), .MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mul_done(mul_done), .bus(bus),
        .ir_we(ir_we), .pc_we(pc_we), .BR(BR), .memToReg(memToReg), .memWrite(memWrite),
        .ALUSrc(ALUSrc), .regWrite(regWrite), .PCToReg(PCToReg), .aluToPC(aluToPC),
        .ALUOp(ALUOp), .mul_start(mul_start), .halt(halt), .illegal(illegal),
        .bus_err(bus_err), .state(state)
    );

    logic [20:0] all_out;
    logic [7:0]  strobes;
    assign all_out = {bus.imem_req, ir_we, bus.dmem_req, pc_we, BR, memToReg, memWrite, ALUSrc,
                      regWrite, PCToReg, aluToPC, ALUOp, mul_start, halt, illegal, bus_err, state};
    assign strobes = {bus.imem_req, ir_we, bus.dmem_req, pc_we, regWrite, memWrite, mul_start, BR};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction-level reference: class, ALU code and {memToReg,ALUSrc,PCToReg,aluToPC}
    function automatic void classify(input logic [31:0] i, output int kind,
                                     output logic [2:0] aop, output logic [3:0] dp);
        logic [6:0] op, f7;
        logic [2:0] f3;
        int         alu_f3;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        kind = K_ILL; aop = 3'd0; dp = 4'b0000;
        case (f3)
            3'd0: alu_f3 = 0;
            3'd1: alu_f3 = 5;
            3'd6: alu_f3 = 4;
            3'd7: alu_f3 = 3;
            default: alu_f3 = -1;
        endcase
        if (op == 7'h33) begin
            if (f7 == 7'h00 && alu_f3 >= 0) begin kind = K_ALU; aop = 3'(alu_f3); end
            else if (f7 == 7'h20 && f3 == 3'd0) begin kind = K_ALU; aop = 3'd1; end
`ifdef MUL_EN
            else if (f7 == 7'h01 && f3 == 3'd0) begin kind = K_MUL; aop = 3'd2; end
`endif
        end else if (op == 7'h13) begin
            if (alu_f3 >= 0 && (f3 != 3'd1 || f7 == 7'h00)) begin
                kind = K_ALU; aop = 3'(alu_f3); dp = 4'b0100;
            end
        end else if (op == 7'h03 && f3 == 3'd2) begin kind = K_LW; dp = 4'b1100; end
        else if (op == 7'h23 && f3 == 3'd2) begin kind = K_SW; dp = 4'b0100; end
        else if (op == 7'h63 && f3 == 3'd0) begin kind = K_B; aop = 3'd1; end
        else if (op == 7'h6F) begin kind = K_ALU; dp = 4'b0110; end
        else if (op == 7'h67 && f3 == 3'd0) begin kind = K_ALU; dp = 4'b0111; end
        else if (op == 7'h7F) kind = K_HALT;
    endfunction

    function automatic logic [31:0] gen_instr(input int sel);
        logic [31:0] r;
        logic [2:0]  f3tab [4];
        logic [6:0]  optab [7];
        int          c;
        f3tab = '{3'd0, 3'd1, 3'd6, 3'd7};
        optab = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
        r = $urandom;
        c = $urandom_range(0, 5);
        case (sel)
            0: begin
                r[6:0] = 7'h33;
                if (c < 4) begin r[14:12] = f3tab[c]; r[31:25] = 7'h00; end
                else begin r[14:12] = 3'd0; r[31:25] = (c == 4) ? 7'h20 : 7'h01; end
            end
            1: begin
                r[6:0] = 7'h13; r[14:12] = f3tab[c % 4];
                if (r[14:12] == 3'd1) r[31:25] = 7'h00;
            end
            2: begin r[6:0] = 7'h03; r[14:12] = 3'd2; end
            3: begin r[6:0] = 7'h23; r[14:12] = 3'd2; end
            4: begin r[6:0] = 7'h63; r[14:12] = 3'd0; end
            5: r[6:0] = 7'h6F;
            6: begin r[6:0] = 7'h67; r[14:12] = 3'd0; end
            7: ;
            default: r[6:0] = optab[$urandom_range(0, 6)];
        endcase
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; mul_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'(all_out), 32'd0);
        rst = 1'b0;
        #1;
        check("reset_release_idle", 32'(bus.imem_req), 32'd0);
    endtask

    // Runs one instruction from its first FETCH cycle; di/dd/md are the wait
    // cycles before imem_ready, dmem_ready and mul_done respectively.
    task automatic run(input logic [31:0] ins, input int di, input int dd, input int md);
        int kind, lat, tcyc, cyc, fcnt, mcnt, ucnt;
        int n_ir, ir_cyc, n_pc, pc_cyc, n_rw, rw_cyc, n_br, n_dq, n_mw, n_ms, n_term;
        logic [2:0] aop, tstate, tflags;
        logic [3:0] dp;
        logic [6:0] ctl, ctl0;
        bit mstarted, done, unstable, writer;
        classify(ins, kind, aop, dp);
        tcyc = 0; tstate = 3'd0; tflags = 3'b000; lat = 0;
        if (di >= MEM_WAIT_MAX) begin tcyc = MEM_WAIT_MAX + 1; tstate = 3'd6; tflags = 3'b001; end
        else if (kind == K_ILL) begin tcyc = di + 3; tstate = 3'd6; tflags = 3'b010; end
        else if (kind == K_HALT) begin tcyc = di + 3; tstate = 3'd5; tflags = 3'b100; end
        else if ((kind == K_LW || kind == K_SW) && dd >= MEM_WAIT_MAX) begin
            tcyc = di + MEM_WAIT_MAX + 4; tstate = 3'd6; tflags = 3'b001;
        end else if (kind == K_MUL && md >= MEM_WAIT_MAX) begin
            tcyc = di + MEM_WAIT_MAX + 3; tstate = 3'd6; tflags = 3'b001;
        end else begin
            case (kind)
                K_B:     lat = di + 3;
                K_MUL:   lat = di + md + 4;
                K_LW:    lat = di + dd + 5;
                K_SW:    lat = di + dd + 4;
                default: lat = di + 4;
            endcase
        end
        instr = ins;
        cyc = 0; fcnt = 0; mcnt = 0; ucnt = 0; mstarted = 0; done = 0; unstable = 0;
        n_ir = 0; ir_cyc = 0; n_pc = 0; pc_cyc = 0; n_rw = 0; rw_cyc = 0;
        n_br = 0; n_dq = 0; n_mw = 0; n_ms = 0; n_term = 0; ctl0 = 7'd0;
        while (!done) begin
            @(posedge clk); #1;
            cyc++;
            bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; mul_done = 1'b0;
            if (bus.imem_req) begin bus.imem_ready = (fcnt == di); fcnt++; end
            if (bus.dmem_req) begin bus.dmem_ready = (mcnt == dd); mcnt++; end
            if (mul_start) mstarted = 1;
            if (mstarted) begin mul_done = (ucnt == md); ucnt++; end
            #1;
            if (cyc == 1) check("start_fetch", {28'd0, bus.imem_req, state}, {28'd0, 1'b1, 3'd0});
            n_ir += int'(ir_we); n_pc += int'(pc_we); n_rw += int'(regWrite); n_br += int'(BR);
            n_dq += int'(bus.dmem_req); n_mw += int'(memWrite); n_ms += int'(mul_start);
            if (ir_we) ir_cyc = cyc;
            if (pc_we) pc_cyc = cyc;
            if (regWrite) rw_cyc = cyc;
            ctl = {memToReg, ALUSrc, PCToReg, aluToPC, ALUOp};
            if (tcyc == 0 && cyc == di + 3) ctl0 = ctl;
            else if (tcyc == 0 && cyc > di + 3 && ctl !== ctl0) unstable = 1;
            if (tcyc != 0 && cyc == tcyc)
                check("term_entry", {26'd0, state, halt, illegal, bus_err}, {26'd0, tstate, tflags});
            if (tcyc != 0 && cyc > tcyc && strobes != 8'd0) n_term++;
            done = (tcyc == 0) ? (pc_we || cyc >= lat + 8) : (cyc >= tcyc + 20);
        end
        if (tcyc == 0) begin
            writer = (kind == K_ALU || kind == K_LW || kind == K_MUL);
            check("latency", pc_cyc, lat);
            check("ir_we_once", n_ir, 1);
            check("ir_we_cycle", ir_cyc, di + 1);
            check("pc_we_count", n_pc, 1);
            check("regwrite_count", n_rw, writer ? 1 : 0);
            if (writer) check("regwrite_cycle", rw_cyc, lat);
            check("br_count", n_br, (kind == K_B) ? 1 : 0);
            check("dmem_req_cycles", n_dq, (kind == K_LW || kind == K_SW) ? dd + 1 : 0);
            check("memwrite_cycles", n_mw, (kind == K_SW) ? dd + 1 : 0);
            check("mul_start_count", n_ms, (kind == K_MUL) ? 1 : 0);
            check("controls", 32'(ctl0), 32'({dp, aop}));
            check("controls_stable", 32'(unstable), 32'd0);
        end else begin
            check("term_no_commit", n_pc + n_rw, 0);
            check("term_strobes_zero", n_term, 0);
            check("term_hold", {26'd0, state, halt, illegal, bus_err}, {26'd0, tstate, tflags});
            do_reset();
        end
    endtask

    initial begin
        int nmem, ncommit;
        bit seen;
        rst = 1'b1; instr = 32'd0; mul_done = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        #1;
        check("reset_async_initial", 32'(all_out), 32'd0);
        do_reset();

        run(32'h0020_81B3, 0, 0, 0);                // ADD
        run(32'h0000_A103, 0, 3, 0);                // LW, three dmem wait cycles
        run(32'h0020_8463, 0, 0, 0);                // BEQ
        run(32'h4020_81B3, 1, 0, 0);                // SUB with a fetch wait
        run(32'h0020_A423, 2, 1, 0);                // SW
        run(32'h0080_00EF, 0, 0, 0);                // JAL
        run(32'h0000_80E7, 0, 0, 0);                // JALR
        run(32'h0020_81B3, MEM_WAIT_MAX - 1, 0, 0); // ready on last allowed cycle
        run(32'h0000_007F, 0, 0, 0);                // HALT
        run(32'h0020_81B3, MEM_WAIT_MAX, 0, 0);     // fetch timeout
        run(32'h0020_A423, 0, MEM_WAIT_MAX, 0);     // data timeout
        run(32'h0220_81B3, 0, 0, 2);                // MUL encoding
        run(32'h0000_000B, 0, 0, 0);                // unlisted opcode

        // Reset asserted while the data access is pending
        instr = 32'h0000_A103;
        nmem = 0; ncommit = 0; seen = 0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(posedge clk); #1;
            bus.imem_ready = bus.imem_req;
            bus.dmem_ready = 1'b0;
            #1;
            if (bus.dmem_req) nmem++;
            ncommit += int'(pc_we) + int'(regWrite);
            if (nmem == 2) seen = 1;
        end
        check("mem_reached", 32'(seen), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_in_mem", 32'(all_out), 32'd0);
        check("abort_no_commit", ncommit, 0);
        do_reset();

        for (int n = 0; n < 30; n++)
            run(gen_instr($urandom_range(0, 8)), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter ALUOP_W, default 3, SHALL set ALUOp width; legal values are 3 or more, and upper bits beyond [2:0] are zero.
REQ-002 Parameter MEM_WAIT_MAX, default 15, SHALL be the maximum wait cycles for a memory ready before a bus error (1..255).
REQ-003 clk  in  1  the single clock; all state updates occur on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 instr  in  32  instruction register contents; opcode=[6:0], func3=[14:12], func7=[31:25].
REQ-006 imem_ready  in  1  instruction memory completes the fetch this cycle.
REQ-007 dmem_ready  in  1  data memory completes the access this cycle.
REQ-008 mul_done  in  1  multiplier result is valid (used only with MUL_EN).
REQ-009 imem_req, ir_we, dmem_req, pc_we  out  1 each  fetch request, IR load, data access request, PC update.
REQ-010 BR, memToReg, memWrite, ALUSrc, regWrite, PCToReg, aluToPC  out  1 each  datapath controls, same meanings as the single-cycle datapath.
REQ-011 ALUOp  out  ALUOP_W  ALU select: 0=ADD, 1=SUB, 2=MUL, 3=AND, 4=OR, 5=SLL.
REQ-012 mul_start  out  1  one-cycle multiplier start pulse.
REQ-013 halt, illegal, bus_err  out  1 each  sticky terminal status flags.
REQ-014 state  out  3  current FSM state encoding, for debug.

Function
REQ-015 The FSM SHALL use the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
REQ-016 In FETCH the block SHALL assert imem_req, and on imem_ready it SHALL pulse ir_we for one cycle and move to DECODE.
REQ-017 In DECODE the block SHALL classify the opcode as R (0110011), I (0010011), LW (0000011), SW (0100011), B (1100011), JAL (1101111), JALR (1100111) or HALT (1111111).
REQ-018 From DECODE, HALT SHALL go to the HALT state, any unlisted opcode or func3/func7 combination SHALL go to TRAP, and all other opcodes SHALL go to EXEC.
REQ-019 Decoded controls SHALL be registered in DECODE and held stable through the end of the instruction; no output is X in any state.
REQ-020 In EXEC, LW and SW SHALL go to MEM; R, I, JAL and JALR SHALL go to WB; B SHALL assert BR and pc_we for one cycle and go to FETCH.
REQ-021 In MEM the block SHALL assert dmem_req, with memWrite asserted for SW only.
REQ-022 In MEM, on dmem_ready, LW SHALL go to WB and SW SHALL pulse pc_we and go to FETCH.
REQ-023 In WB the block SHALL assert regWrite for exactly one cycle, pulse pc_we, and go to FETCH.
REQ-024 Outside those cycles, regWrite, memWrite and pc_we SHALL be 0.
REQ-025 Instruction latencies SHALL be: R/I/JAL/JALR 4 cycles, B 3 cycles, LW 5 cycles and SW 4 cycles, each with zero-wait memory.
REQ-026 Each wait state (FETCH, MEM) SHALL run a wait counter that clears on state entry.
REQ-027 If ready has not been seen after MEM_WAIT_MAX cycles, the block SHALL set bus_err and go to TRAP.
REQ-028 A ready arriving on the final allowed cycle SHALL be accepted.
REQ-029 HALT and TRAP SHALL be absorbing, holding all strobes at 0; only rst exits them.
REQ-030 halt SHALL be set in HALT; illegal SHALL be set on any decode failure.

Reset
REQ-031 While rst is high, state SHALL be FETCH, all outputs SHALL be 0 (ALUOp=0), and the wait counter SHALL be 0.
REQ-032 imem_req SHALL assert on the first clk edge after rst deasserts.
REQ-033 Reset asserted mid-instruction SHALL abort the instruction immediately with no pc_we or regWrite pulse.

Configuration
REQ-034 With MUL_EN defined, R-type func3=000 with func7=0000001 SHALL decode as MUL (ALUOp=2).
REQ-035 With MUL_EN defined, EXEC for MUL SHALL pulse mul_start on its first cycle, wait for mul_done (subject to the MEM_WAIT_MAX timeout with bus_err), then go to WB.
REQ-036 Without MUL_EN, that encoding SHALL go to TRAP with illegal set, and mul_start SHALL be tied to 0.

Structure
REQ-037 A shared package mc_pkg SHALL hold the opcode constants, ALUOp codes, the FSM state enumeration, and the instruction-class enum.
REQ-038 The combinational decoder SHALL be a sub-module mc_decoder (inputs opcode/func3/func7; outputs instruction class, ALUOp and a valid flag), and the FSM SHALL remain in the top level.

Verification
REQ-039 ADD (func7=0, func3=0) with zero-wait ready SHALL produce ir_we at cycle 1, regWrite at cycle 4, ALUOp=0, one pc_we, and then FETCH.
REQ-040 LW with dmem_ready delayed 3 cycles SHALL hold dmem_req for 4 cycles, with memToReg=1 and regWrite in the following WB cycle (8 cycles total).
REQ-041 BEQ (1100011) SHALL produce ALUOp=1 with BR=1 and pc_we=1 in the same cycle, regWrite=0, and a return to FETCH after 3 cycles.
REQ-042 opcode 1111111 SHALL set halt=1 and state=5, and all strobes SHALL stay 0 for 20 cycles.
REQ-043 imem_ready held low SHALL set bus_err after MEM_WAIT_MAX=15 cycles and enter TRAP; a ready on the 15th cycle SHALL instead be accepted.
REQ-044 A MUL encoding SHALL produce mul_start then WB with MUL_EN defined, and illegal=1 with TRAP without it; rst asserted during MEM SHALL give state=0 and all outputs 0 asynchronously.
